mod_addsub_pipe: RTL and testbench

//  Multi-lane, 2-stage pipelined modular add/sub/negate/double unit with valid/ready flow control.

---
 rtl/mod_addsub_pipe.sv | 115 +++++++++++
 tb/tb_mod_addsub_pipe.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mod_addsub_pipe.sv
// Two-stage, multi-lane modular add/sub/negate/double unit with valid/ready flow control.
// Optional per-lane operand range flags are built when MODPIPE_RANGE_CHECK_EN is defined.
module mod_addsub_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       q,
  input  logic [1:0]             op,
  input  logic [LANES*WIDTH-1:0] in0,
  input  logic [LANES*WIDTH-1:0] in1,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [LANES*WIDTH-1:0] out,
  output logic [LANES-1:0]       err,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam logic [1:0] OpAdd = 2'd0;
  localparam logic [1:0] OpSub = 2'd1;
  localparam logic [1:0] OpNeg = 2'd2;
  localparam logic [1:0] OpDbl = 2'd3;

  logic                        s1_valid, s2_valid;
  logic                        s1_adv, s2_adv;
  logic [LANES-1:0][WIDTH:0]   s1_raw, raw_d;
  logic [WIDTH-1:0]            s1_q;
  logic [1:0]                  s1_op;
  logic [LANES*WIDTH-1:0]      out_d;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [WIDTH:0]   a, b, raw;
    logic [WIDTH-1:0] fix;

    assign a = {1'b0, in0[k*WIDTH +: WIDTH]};
    assign b = {1'b0, in1[k*WIDTH +: WIDTH]};

    // Raw result in WIDTH+1 bits; bit WIDTH is the borrow for SUB/NEG.
    always_comb begin
      raw = a + b;
      unique case (op)
        OpAdd:   raw = a + b;
        OpSub:   raw = a - b;
        OpNeg:   raw = '0 - a;
        OpDbl:   raw = a + a;
        default: raw = a + b;
      endcase
    end
    assign raw_d[k] = raw;

    // Low WIDTH bits of the corrected sum do not depend on the discarded top bit.
    always_comb begin
      fix = s1_raw[k][WIDTH-1:0];
      if (s1_op == OpAdd || s1_op == OpDbl) begin
        if (s1_raw[k] >= {1'b0, s1_q}) fix = s1_raw[k][WIDTH-1:0] - s1_q;
      end else if (s1_raw[k][WIDTH]) begin
        fix = s1_raw[k][WIDTH-1:0] + s1_q;
      end
    end
    assign out_d[k*WIDTH +: WIDTH] = fix;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_raw   <= '0;
      s1_q     <= '0;
      s1_op    <= '0;
      s2_valid <= 1'b0;
      out      <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_raw <= raw_d;
          s1_q   <= q;
          s1_op  <= op;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) out <= out_d;
      end
    end
  end

`ifdef MODPIPE_RANGE_CHECK_EN
  logic [LANES-1:0] err_d, s1_err;

  for (genvar k = 0; k < LANES; k++) begin : g_err
    assign err_d[k] = (in0[k*WIDTH +: WIDTH] >= q) ||
                      ((op == OpAdd || op == OpSub) && (in1[k*WIDTH +: WIDTH] >= q));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_err <= '0;
      err    <= '0;
    end else begin
      if (s1_adv && in_valid) s1_err <= err_d;
      if (s2_adv && s1_valid) err <= s1_err;
    end
  end
`else
  assign err = '0;
`endif

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Directed and scoreboarded checks for mod_addsub_pipe (WIDTH=16, LANES=4, q=251).
// Expected err values follow MODPIPE_RANGE_CHECK_EN when it is defined for the build.
module tb_mod_addsub_pipe;

  localparam int Q = 251;

  logic        clk, reset;
  logic [15:0] q;
  logic [1:0]  op;
  logic [63:0] in0, in1, out;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  err;

  int n_checks = 0;
  int n_errors = 0;

  mod_addsub_pipe #(.WIDTH(16), .LANES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .q         (q),
    .op        (op),
    .in0       (in0),
    .in1       (in1),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int v0, input int v1, input int v2, input int v3);
    return {v3[15:0], v2[15:0], v1[15:0], v0[15:0]};
  endfunction

  function automatic logic [63:0] model(input logic [1:0] o, input logic [63:0] a,
                                        input logic [63:0] b);
    logic [63:0] r;
    int x, y, v;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      x = int'(a[k*16 +: 16]);
      y = int'(b[k*16 +: 16]);
      case (o)
        2'd0:    v = (x + y) % Q;
        2'd1:    v = (x - y + Q) % Q;
        2'd2:    v = (Q - x) % Q;
        default: v = (2 * x) % Q;
      endcase
      r[k*16 +: 16] = v[15:0];
    end
    return r;
  endfunction

  // Single beat through an idle pipeline; called at posedge+1.
  task automatic run_one(input string tag, input logic [1:0] o, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input logic [3:0] exp_err);
    op = o; in0 = a; in1 = b; in_valid = 1'b1; out_ready = 1'b1;
    #1 check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, " valid_c1"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check({tag, " valid_c2"}, 64'(out_valid), 64'd1);
    check({tag, " out"}, out, exp);
    check({tag, " err"}, 64'(err), 64'(exp_err));
    @(posedge clk); #1;
  endtask

  logic [63:0] exp_q[$];
  logic [63:0] cur_a, cur_b, ea, eb, ec, ed;
  logic [1:0]  cur_op;
  logic [3:0]  range_err;
  int sent, rcvd, cyc;

  task automatic gen_beat();
    cur_op = 2'($urandom_range(0, 3));
    for (int k = 0; k < 4; k++) begin
      cur_a[k*16 +: 16] = 16'($urandom_range(0, Q - 1));
      cur_b[k*16 +: 16] = 16'($urandom_range(0, Q - 1));
    end
  endtask

  initial begin
    reset = 1'b0; q = 16'(Q); op = '0; in0 = '0; in1 = '0;
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out", out, 64'd0);
    check("rst err", 64'(err), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    run_one("add", 2'd0, pk(200, 0, 250, 1), pk(100, 0, 250, 249), pk(49, 0, 249, 250), 4'b0);
    run_one("sub", 2'd1, pk(10, 0, 250, 5), pk(20, 0, 0, 5), pk(241, 0, 250, 0), 4'b0);
    run_one("neg", 2'd2, pk(0, 5, 250, 1), pk(0, 0, 0, 0), pk(0, 246, 1, 250), 4'b0);
    run_one("dbl", 2'd3, pk(200, 125, 0, 126), pk(0, 0, 0, 0), pk(149, 250, 0, 1), 4'b0);
`ifdef MODPIPE_RANGE_CHECK_EN
    range_err = 4'b0011;
`else
    range_err = 4'b0000;
`endif
    run_one("range", 2'd0, pk(300, 0, 0, 0), pk(0, 251, 0, 0), pk(49, 0, 0, 0), range_err);

    // Random stream with random backpressure against the behavioural model.
    sent = 0; rcvd = 0; cyc = 0;
    gen_beat();
    while (rcvd < 32 && cyc < 2000) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 32);
      op = cur_op; in0 = cur_a; in1 = cur_b;
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("stream extra", 64'd1, 64'd0);
        else check("stream", out, exp_q.pop_front());
        rcvd++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(cur_op, cur_a, cur_b));
        sent++;
        gen_beat();
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream sent", 64'(sent), 64'd32);
    check("stream rcvd", 64'(rcvd), 64'd32);
    @(posedge clk); #1;
    check("stream drained", 64'(out_valid), 64'd0);

    // Backpressure: fill both stages, hold, then release.
    ea = pk(1, 2, 3, 4); eb = pk(5, 6, 7, 8); ec = pk(9, 10, 11, 12); ed = pk(13, 14, 15, 16);
    op = 2'd0; in1 = '0; out_ready = 1'b0; in0 = ea; in_valid = 1'b1;
    @(posedge clk); #1 in0 = eb;
    @(posedge clk); #1 in0 = ec;
    #1;
    check("full in_ready", 64'(in_ready), 64'd0);
    check("full out", out, ea);
    @(posedge clk); #1;
    check("hold out", out, ea);
    check("hold valid", 64'(out_valid), 64'd1);
    check("hold in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1 check("release in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1 in0 = ed;
    #1;
    check("resume out B", out, eb);
    check("resume in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    check("resume out C", out, ec);
    @(posedge clk); #1;
    check("resume out D", out, ed);
    @(posedge clk); #1;
    check("resume empty", 64'(out_valid), 64'd0);

    // Asynchronous reset with two beats in flight.
    in0 = ea; in_valid = 1'b1;
    @(posedge clk); #1 in0 = eb;
    @(posedge clk); #1 in_valid = 1'b0;
    check("pre-reset valid", 64'(out_valid), 64'd1);
    reset = 1'b0;
    #1;
    check("async valid", 64'(out_valid), 64'd0);
    check("async out", out, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("discarded", 64'(out_valid), 64'd0);
    run_one("post-reset", 2'd1, pk(10, 0, 250, 5), pk(20, 0, 0, 5), pk(241, 0, 250, 0), 4'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
